// File: rtl/npc_pkg.sv
// Shared encodings and target arithmetic for the next-PC / branch prediction unit.
package npc_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // PC-relative branch target: word offset measured from the delay-free PC+4.
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] offset);
    return pc + 32'd4 + {{14{offset[15]}}, offset, 2'b00};
  endfunction

  // Pseudo-direct jump target: keeps the top nibble of the jump's own PC.
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] imm);
    return {pc[31:28], imm, 2'b00};
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: async lookup port, synchronous update port with
// 2-bit saturating counters.
module btb_table
  import npc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit_c,
  output logic             rd_taken_c,
  output logic [31:0]      rd_target_c,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic             upd_taken,
  input  logic             upd_is_jump,
  input  logic [31:0]      upd_target
);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [1:0]       ctr_q    [DEPTH];

  logic       upd_hit;
  logic       upd_write;
  logic [1:0] upd_ctr;
  logic [1:0] ctr_nxt;

  // Lookup reads the pre-update contents, so a same-cycle update is not forwarded.
  assign rd_hit_c    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken_c  = ctr_q[rd_idx][1];
  assign rd_target_c = target_q[rd_idx];

  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr   = ctr_q[upd_idx];
  assign upd_write = upd_en && (upd_hit || upd_taken);

  always_comb begin
    ctr_nxt = upd_ctr;
    if (upd_hit) begin
      if (upd_taken)
        ctr_nxt = (upd_ctr == CTR_ST) ? CTR_ST : 2'(upd_ctr + 2'd1);
      else
        ctr_nxt = (upd_ctr == CTR_SNT) ? CTR_SNT : 2'(upd_ctr - 2'd1);
    end else begin
      ctr_nxt = upd_is_jump ? CTR_ST : CTR_WT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      valid_q <= '0;
    else if (upd_write && !upd_hit)
      valid_q[upd_idx] <= 1'b1;
  end

  // Data arrays need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (upd_write) begin
      ctr_q[upd_idx] <= ctr_nxt;
      if (upd_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
      end
    end
  end

endmodule

// File: rtl/npc_bp.sv
// Fetch PC register with BTB-based next-PC prediction and D-stage resolution,
// redirect and mispredict counting.
module npc_bp
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned BTB_DEPTH   = 16,
  parameter int unsigned TAG_W       = 10,
  parameter bit          ENABLE_PRED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] F_PC,
  output logic        F_pred_taken,
  output logic [31:0] F_pred_target,
  input  logic        D_valid,
  input  logic [31:0] D_PC,
  input  logic        D_is_branch,
  input  logic        D_is_jump,
  input  logic        D_jump_reg,
  input  logic        D_cond,
  input  logic [15:0] D_offset,
  input  logic [25:0] D_imm,
  input  logic [31:0] D_rs,
  input  logic [31:0] D_pred_next,
  output logic        redirect,
  output logic [31:0] mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);

  logic [31:0] pc_q;
  logic [31:0] cnt_q;

  logic             btb_hit;
  logic             btb_taken;
  logic [31:0]      btb_target;
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [31:0]      pc_plus4;

  logic [31:0] d_jump_tgt;
  logic [31:0] d_actual_next;
  logic        d_taken;
  logic        btb_upd;

  assign f_idx    = pc_q[IDX_W+1:2];
  assign f_tag    = pc_q[IDX_W+TAG_W+1:IDX_W+2];
  assign pc_plus4 = pc_q + 32'd4;

  assign F_PC          = pc_q;
  assign F_pred_taken  = ENABLE_PRED && btb_hit && btb_taken;
  assign F_pred_target = F_pred_taken ? btb_target : pc_plus4;

  // D-stage resolution of the real next PC.
  assign d_jump_tgt    = D_jump_reg ? D_rs : jump_target(D_PC, D_imm);
  assign d_taken       = D_is_jump || (D_is_branch && D_cond);
  assign d_actual_next = D_is_jump ? d_jump_tgt
                       : (D_is_branch && D_cond) ? branch_target(D_PC, D_offset)
                       : 32'(D_PC + 32'd4);

  assign redirect = reset && D_valid && !stall && (d_actual_next != D_pred_next);
  assign btb_upd  = reset && D_valid && !stall && (D_is_branch || D_is_jump);

  btb_table #(
    .DEPTH (BTB_DEPTH),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .rd_idx      (f_idx),
    .rd_tag      (f_tag),
    .rd_hit_c    (btb_hit),
    .rd_taken_c  (btb_taken),
    .rd_target_c (btb_target),
    .upd_en      (btb_upd),
    .upd_idx     (D_PC[IDX_W+1:2]),
    .upd_tag     (D_PC[IDX_W+TAG_W+1:IDX_W+2]),
    .upd_taken   (d_taken),
    .upd_is_jump (D_is_jump),
    .upd_target  (d_actual_next)
  );

  // Redirect already excludes stall, so a held mismatch is counted once it releases.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else if (!stall) begin
      pc_q <= redirect ? d_actual_next : F_pred_target;
      if (redirect)
        cnt_q <= cnt_q + 32'd1;
    end
  end

  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_npc_bp.sv
// Directed tests for npc_bp: reset, cold/warm branches, counter decay, stall,
// aliasing and the prediction-disabled build.
module tb_npc_bp;

  logic        clk = 1'b0;
  logic        reset, reset_np, stall;
  logic        D_valid, D_is_branch, D_is_jump, D_jump_reg, D_cond;
  logic [31:0] D_PC, D_rs, D_pred_next;
  logic [15:0] D_offset;
  logic [25:0] D_imm;

  logic [31:0] F_PC, F_pred_target, mispredict_cnt;
  logic        F_pred_taken, redirect;
  logic [31:0] F_PC_np, F_pred_target_np, mispredict_cnt_np;
  logic        F_pred_taken_np, redirect_np;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  npc_bp u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .F_PC(F_PC), .F_pred_taken(F_pred_taken), .F_pred_target(F_pred_target),
    .D_valid(D_valid), .D_PC(D_PC), .D_is_branch(D_is_branch), .D_is_jump(D_is_jump),
    .D_jump_reg(D_jump_reg), .D_cond(D_cond), .D_offset(D_offset), .D_imm(D_imm),
    .D_rs(D_rs), .D_pred_next(D_pred_next),
    .redirect(redirect), .mispredict_cnt(mispredict_cnt)
  );

  npc_bp #(.ENABLE_PRED(1'b0)) u_dut_np (
    .clk(clk), .reset(reset_np), .stall(stall),
    .F_PC(F_PC_np), .F_pred_taken(F_pred_taken_np), .F_pred_target(F_pred_target_np),
    .D_valid(D_valid), .D_PC(D_PC), .D_is_branch(D_is_branch), .D_is_jump(D_is_jump),
    .D_jump_reg(D_jump_reg), .D_cond(D_cond), .D_offset(D_offset), .D_imm(D_imm),
    .D_rs(D_rs), .D_pred_next(D_pred_next),
    .redirect(redirect_np), .mispredict_cnt(mispredict_cnt_np)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic d_idle;
    D_valid = 0; D_is_branch = 0; D_is_jump = 0; D_jump_reg = 0; D_cond = 0;
    D_PC = '0; D_rs = '0; D_pred_next = '0; D_offset = '0; D_imm = '0; stall = 0;
  endtask

  task automatic d_branch(input logic [31:0] pc, input logic [15:0] off, input logic cond,
                          input logic [31:0] pn);
    d_idle;
    D_valid = 1; D_is_branch = 1; D_PC = pc; D_offset = off; D_cond = cond; D_pred_next = pn;
  endtask

  task automatic d_jump(input logic [31:0] pc, input logic [25:0] imm, input logic [31:0] pn);
    d_idle;
    D_valid = 1; D_is_jump = 1; D_PC = pc; D_imm = imm; D_pred_next = pn;
  endtask

  task automatic d_jr(input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] pn);
    d_idle;
    D_valid = 1; D_is_jump = 1; D_jump_reg = 1; D_PC = pc; D_rs = rs; D_pred_next = pn;
  endtask

  // Non-control instruction with a bogus carried prediction: forces a redirect to PC+4
  // without touching the BTB.
  task automatic d_plain(input logic [31:0] pc, input logic [31:0] pn);
    d_idle;
    D_valid = 1; D_PC = pc; D_pred_next = pn;
  endtask

  task automatic do_reset;
    d_idle;
    reset = 0;
    tick; tick;
    reset = 1;
  endtask

  task automatic test_reset;
    reset = 0; reset_np = 0;
    d_jump(32'h3008, 26'h400, 32'h0);
    tick; tick;
    total++; if (redirect !== 1'b0) $display("FAIL rst_redirect got %b exp 0", redirect); else passed++;
    total++; if (F_PC !== 32'h3000) $display("FAIL rst_pc got %h exp 00003000", F_PC); else passed++;
    total++; if (F_pred_taken !== 1'b0) $display("FAIL rst_taken got %b exp 0", F_pred_taken); else passed++;
    total++; if (F_pred_target !== 32'h3004) $display("FAIL rst_target got %h exp 00003004", F_pred_target); else passed++;
    total++; if (mispredict_cnt !== 32'd0) $display("FAIL rst_cnt got %0d exp 0", mispredict_cnt); else passed++;
    d_idle;
    reset = 1;
    tick;
    total++; if (F_PC !== 32'h3004) $display("FAIL rel_pc1 got %h exp 00003004", F_PC); else passed++;
    tick;
    total++; if (F_PC !== 32'h3008) $display("FAIL rel_pc2 got %h exp 00003008", F_PC); else passed++;
    total++; if (F_pred_taken !== 1'b0) $display("FAIL rst_nowrite got %b exp 0", F_pred_taken); else passed++;
    total++; if (F_pred_target !== 32'h300C) $display("FAIL rel_target got %h exp 0000300c", F_pred_target); else passed++;
  endtask

  task automatic test_cold_branch;
    tick;
    d_branch(32'h3008, 16'h0004, 1'b1, 32'h300C);
    #1;
    total++; if (redirect !== 1'b1) $display("FAIL cold_redirect got %b exp 1", redirect); else passed++;
    tick; d_idle;
    total++; if (F_PC !== 32'h301C) $display("FAIL cold_pc got %h exp 0000301c", F_PC); else passed++;
    total++; if (mispredict_cnt !== 32'd1) $display("FAIL cold_cnt got %0d exp 1", mispredict_cnt); else passed++;
    d_jr(32'h5000, 32'h3008, 32'h5004);
    #1;
    total++; if (redirect !== 1'b1) $display("FAIL jr_redirect got %b exp 1", redirect); else passed++;
    tick; d_idle;
    total++; if (F_PC !== 32'h3008) $display("FAIL refetch_pc got %h exp 00003008", F_PC); else passed++;
    total++; if (F_pred_taken !== 1'b1) $display("FAIL warm_taken got %b exp 1", F_pred_taken); else passed++;
    total++; if (F_pred_target !== 32'h301C) $display("FAIL warm_target got %h exp 0000301c", F_pred_target); else passed++;
    tick;
    d_branch(32'h3008, 16'h0004, 1'b1, 32'h301C);
    #1;
    total++; if (redirect !== 1'b0) $display("FAIL warm_redirect got %b exp 0", redirect); else passed++;
    tick; d_idle;
    total++; if (F_PC !== 32'h3020) $display("FAIL warm_pc got %h exp 00003020", F_PC); else passed++;
    total++; if (mispredict_cnt !== 32'd2) $display("FAIL warm_cnt got %0d exp 2", mispredict_cnt); else passed++;
  endtask

  task automatic test_not_taken;
    do_reset;
    total++; if (mispredict_cnt !== 32'd0) $display("FAIL nt_cnt0 got %0d exp 0", mispredict_cnt); else passed++;
    d_branch(32'h3008, 16'h0004, 1'b1, 32'h300C);
    tick; d_idle;
    d_branch(32'h3008, 16'h0004, 1'b0, 32'h301C);
    #1;
    total++; if (redirect !== 1'b1) $display("FAIL nt_redirect got %b exp 1", redirect); else passed++;
    tick; d_idle;
    total++; if (F_PC !== 32'h300C) $display("FAIL nt_pc got %h exp 0000300c", F_PC); else passed++;
    total++; if (mispredict_cnt !== 32'd2) $display("FAIL nt_cnt got %0d exp 2", mispredict_cnt); else passed++;
    d_plain(32'h3004, 32'h0);
    tick; d_idle;
    total++; if (F_PC !== 32'h3008) $display("FAIL nt_refetch got %h exp 00003008", F_PC); else passed++;
    total++; if (F_pred_taken !== 1'b0) $display("FAIL wnt_taken got %b exp 0", F_pred_taken); else passed++;
    total++; if (F_pred_target !== 32'h300C) $display("FAIL wnt_target got %h exp 0000300c", F_pred_target); else passed++;
    total++; if (mispredict_cnt !== 32'd3) $display("FAIL plain_cnt got %0d exp 3", mispredict_cnt); else passed++;
  endtask

  task automatic test_stall;
    d_jr(32'h3010, 32'h4000, 32'h3014);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (redirect !== 1'b0) $display("FAIL stall_redirect%0d got %b exp 0", i, redirect); else passed++;
      tick;
      total++; if (F_PC !== 32'h3008) $display("FAIL stall_pc%0d got %h exp 00003008", i, F_PC); else passed++;
      total++; if (mispredict_cnt !== 32'd3) $display("FAIL stall_cnt%0d got %0d exp 3", i, mispredict_cnt); else passed++;
    end
    stall = 0;
    #1;
    total++; if (redirect !== 1'b1) $display("FAIL unstall_redirect got %b exp 1", redirect); else passed++;
    tick; d_idle;
    total++; if (F_PC !== 32'h4000) $display("FAIL unstall_pc got %h exp 00004000", F_PC); else passed++;
    total++; if (mispredict_cnt !== 32'd4) $display("FAIL unstall_cnt got %0d exp 4", mispredict_cnt); else passed++;
    d_plain(32'h300C, 32'h0);
    tick; d_idle;
    total++; if (F_pred_taken !== 1'b1) $display("FAIL jr_btb_taken got %b exp 1", F_pred_taken); else passed++;
    total++; if (F_pred_target !== 32'h4000) $display("FAIL jr_btb_target got %h exp 00004000", F_pred_target); else passed++;
    tick;
    total++; if (F_PC !== 32'h4000) $display("FAIL jr_pred_pc got %h exp 00004000", F_PC); else passed++;
  endtask

  task automatic test_targets;
    d_jump(32'h9000_0010, 26'h000_0100, 32'h9000_0014);
    #1;
    total++; if (redirect !== 1'b1) $display("FAIL j_redirect got %b exp 1", redirect); else passed++;
    tick; d_idle;
    total++; if (F_PC !== 32'h9000_0400) $display("FAIL j_pc got %h exp 90000400", F_PC); else passed++;
    d_branch(32'h3100, 16'hFFFC, 1'b1, 32'h3104);
    tick; d_idle;
    total++; if (F_PC !== 32'h30F4) $display("FAIL neg_off_pc got %h exp 000030f4", F_PC); else passed++;
    total++; if (mispredict_cnt !== 32'd7) $display("FAIL tgt_cnt got %0d exp 7", mispredict_cnt); else passed++;
    d_branch(32'h3100, 16'hFFFC, 1'b0, 32'h3104);
    #1;
    total++; if (redirect !== 1'b0) $display("FAIL nt_correct got %b exp 0", redirect); else passed++;
    d_jump(32'h3200, 26'h123, 32'h0);
    D_valid = 0;
    #1;
    total++; if (redirect !== 1'b0) $display("FAIL bubble_redirect got %b exp 0", redirect); else passed++;
    tick; d_idle;
    total++; if (mispredict_cnt !== 32'd7) $display("FAIL bubble_cnt got %0d exp 7", mispredict_cnt); else passed++;
  endtask

  task automatic test_alias;
    do_reset;
    d_branch(32'h3008, 16'h0004, 1'b1, 32'h300C);
    tick; d_idle;
    d_plain(32'h3044, 32'h0);
    tick; d_idle;
    total++; if (F_PC !== 32'h3048) $display("FAIL alias_pc got %h exp 00003048", F_PC); else passed++;
    total++; if (F_pred_taken !== 1'b0) $display("FAIL alias_taken got %b exp 0", F_pred_taken); else passed++;
    total++; if (F_pred_target !== 32'h304C) $display("FAIL alias_target got %h exp 0000304c", F_pred_target); else passed++;
    d_branch(32'h3048, 16'h0004, 1'b1, 32'h304C);
    tick; d_idle;
    total++; if (F_PC !== 32'h305C) $display("FAIL alias_br_pc got %h exp 0000305c", F_PC); else passed++;
    d_plain(32'h3004, 32'h0);
    tick; d_idle;
    total++; if (F_pred_taken !== 1'b0) $display("FAIL evicted_taken got %b exp 0", F_pred_taken); else passed++;
    total++; if (F_pred_target !== 32'h300C) $display("FAIL evicted_target got %h exp 0000300c", F_pred_target); else passed++;
    d_plain(32'h3044, 32'h0);
    tick; d_idle;
    total++; if (F_pred_taken !== 1'b1) $display("FAIL new_owner_taken got %b exp 1", F_pred_taken); else passed++;
    total++; if (F_pred_target !== 32'h305C) $display("FAIL new_owner_target got %h exp 0000305c", F_pred_target); else passed++;
    total++; if (mispredict_cnt !== 32'd5) $display("FAIL alias_cnt got %0d exp 5", mispredict_cnt); else passed++;
  endtask

  task automatic test_no_pred;
    d_idle;
    reset_np = 0;
    tick;
    total++; if (mispredict_cnt_np !== 32'd0) $display("FAIL np_cnt0 got %0d exp 0", mispredict_cnt_np); else passed++;
    tick;
    reset_np = 1;
    for (int i = 0; i < 2; i++) begin
      d_branch(32'h3008, 16'h0004, 1'b1, 32'h300C);
      #1;
      total++; if (redirect_np !== 1'b1) $display("FAIL np_redirect%0d got %b exp 1", i, redirect_np); else passed++;
      tick;
    end
    d_idle;
    total++; if (F_PC_np !== 32'h301C) $display("FAIL np_pc got %h exp 0000301c", F_PC_np); else passed++;
    total++; if (mispredict_cnt_np !== 32'd2) $display("FAIL np_cnt got %0d exp 2", mispredict_cnt_np); else passed++;
    d_plain(32'h3004, 32'h0);
    tick; d_idle;
    total++; if (F_PC_np !== 32'h3008) $display("FAIL np_refetch got %h exp 00003008", F_PC_np); else passed++;
    total++; if (F_pred_taken_np !== 1'b0) $display("FAIL np_taken got %b exp 0", F_pred_taken_np); else passed++;
    total++; if (F_pred_target_np !== 32'h300C) $display("FAIL np_target got %h exp 0000300c", F_pred_target_np); else passed++;
  endtask

  initial begin
    d_idle;
    test_reset;
    test_cold_branch;
    test_not_taken;
    test_stall;
    test_targets;
    test_alias;
    test_no_pred;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
